// File: rtl/rr_priority_arbiter.sv
// Registered N-way arbiter: grant is locked to one requester until it releases
// or the optional hold timeout expires; fixed or round-robin priority.
module rr_priority_arbiter #(
  parameter int N           = 4,
  parameter int ROUND_ROBIN = 1,
  parameter int MAX_HOLD    = 0,
  localparam int UW         = $clog2(N)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [N-1:0]  request,
  output logic          valid,
  output logic [UW-1:0] user,
  output logic [N-1:0]  grant
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  localparam int          HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned NU = N;

  logic [0:0]    r_state;
  logic [UW-1:0] r_ptr;
  logic [HW-1:0] r_hold;
  logic          r_valid;
  logic [UW-1:0] r_user;
  logic [N-1:0]  r_grant;

  logic [UW-1:0] w_winner;
  logic [N-1:0]  w_onehot;
  logic          w_found;
  logic          w_timeout;
  logic          w_release;
  logic [UW-1:0] w_ptr_next;
  int unsigned   w_idx;

  // Scan from the rotating pointer (round-robin) or from index 0 (fixed).
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_idx    = 0;
    for (int unsigned i = 0; i < NU; i++) begin
      if (ROUND_ROBIN != 0) w_idx = (int'(r_ptr) + i) % NU;
      else                  w_idx = i;
      if (!w_found && request[w_idx[UW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[UW-1:0];
      end
    end
  end

  assign w_onehot   = {{(N-1){1'b0}}, 1'b1} << w_winner;
  assign w_timeout  = (MAX_HOLD > 0) && (int'(r_hold) == MAX_HOLD - 1);
  assign w_release  = !request[r_user] || w_timeout;
  assign w_ptr_next = (r_user == UW'(N - 1)) ? '0 : r_user + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_hold  <= '0;
      r_valid <= 1'b0;
      r_user  <= '0;
      r_grant <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|request) begin
            r_valid <= 1'b1;
            r_user  <= w_winner;
            r_grant <= w_onehot;
            r_hold  <= '0;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_valid <= 1'b0;
            r_user  <= '0;
            r_grant <= '0;
            r_state <= S_IDLE;
            if (ROUND_ROBIN != 0) r_ptr <= w_ptr_next;
          end else if (MAX_HOLD > 0) begin
            // Reaching MAX_HOLD-1 always releases, so this never overflows.
            r_hold <= r_hold + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign valid = r_valid;
  assign user  = r_user;
  assign grant = r_grant;

endmodule
